// File: rtl/hazard_pkg.sv
// Shared types and helpers for the EXE-stage forwarding / load-use hazard unit.
package hazard_pkg;

  // Register index width used when a client does not override it.
  localparam int REG_AW_DEFAULT = 5;

  // Select value meaning "take the operand from the register file".
  localparam int SEL_RF = 0;

  // In-flight destination tag for the default register width.
  typedef struct packed {
    logic                      valid;
    logic                      wb_en;
    logic                      is_load;
    logic [REG_AW_DEFAULT-1:0] dest;
  } tag_t;

  // Width of a forward select able to name RF (0) plus stages 1..depth.
  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One EXE source operand compared against the forwardable stages (1..FWD_DEPTH).
// Produces a priority-encoded select (youngest stage wins) and flags a load
// sitting in MEM that this operand would need.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int FWD_DEPTH   = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int SEL_W       = sel_width(FWD_DEPTH)
) (
  input  logic [REG_AW-1:0]           src_i,
  input  logic [FWD_DEPTH:1]          stg_valid_i,
  input  logic [FWD_DEPTH:1]          stg_wb_en_i,
  input  logic [FWD_DEPTH:1]          stg_is_load_i,
  input  logic [FWD_DEPTH*REG_AW-1:0] stg_dest_i,
  output logic [SEL_W-1:0]            sel_o,
  output logic                        load_hit_o
);

  logic [FWD_DEPTH:1] hit;

  // Raw per-stage match: a live writer to the same, non-zero register.
  for (genvar gi = 1; gi <= FWD_DEPTH; gi++) begin : g_hit
    logic [REG_AW-1:0] stg_dest;
    assign stg_dest = stg_dest_i[(gi-1)*REG_AW +: REG_AW];
    assign hit[gi]  = stg_valid_i[gi] & stg_wb_en_i[gi] & (stg_dest == src_i) &
                      ((ZERO_REG_EN == 0) | (stg_dest != '0));
  end

  // Load data is not available until it leaves MEM, so MEM never forwards a load.
  assign load_hit_o = hit[1] & stg_is_load_i[1];

  // Walk oldest to youngest so the youngest eligible stage overwrites the select.
  always_comb begin
    sel_o = SEL_W'(SEL_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (hit[k] && !(stg_is_load_i[k] && (k == 1))) begin
        sel_o = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EXE-stage forwarding and load-use hazard controller.
// Tracks in-flight destination tags from EXE to WB, drives a bypass select for
// each EXE source operand, stalls ID one cycle on a load-use hazard and counts
// stall cycles (saturating).
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int FWD_DEPTH   = 2,
  parameter int ZERO_REG_EN = 1,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = sel_width(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      id_valid,
  input  logic [REG_AW-1:0]         id_dest,
  input  logic                      id_wb_en,
  input  logic                      id_is_load,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [NUM_SRC*REG_AW-1:0] exe_src,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_id,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Tag pipeline: index 0 = EXE, FWD_DEPTH = WB.
  logic [FWD_DEPTH:0] valid_q, valid_d;
  logic [FWD_DEPTH:0] wb_en_q, wb_en_d;
  logic [FWD_DEPTH:0] is_load_q, is_load_d;
  logic [REG_AW-1:0]  dest_q [0:FWD_DEPTH];
  logic [REG_AW-1:0]  dest_d [0:FWD_DEPTH];

  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_SRC-1:0] use_hit;
  logic [NUM_SRC-1:0] load_hit;
  logic               load_dest_ok;
  logic [FWD_DEPTH*REG_AW-1:0] stg_dest;

  // ---------------------------------------------------------------------------
  // Load-use detection against the load currently in EXE.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_use
    assign use_hit[gi] = id_src_used[gi] & (id_src[gi*REG_AW +: REG_AW] == dest_q[0]);
  end

  assign load_dest_ok = (ZERO_REG_EN == 0) || (dest_q[0] != '0);

  // Flush kills the ID instruction, so it can never be the victim of a hazard.
  assign stall_id = id_valid & ~flush & valid_q[0] & is_load_q[0] & wb_en_q[0] &
                    load_dest_ok & (|use_hit);

  // ---------------------------------------------------------------------------
  // Tag pipeline next state: ID enters EXE unless stalled or flushed; later
  // stages always advance.
  // ---------------------------------------------------------------------------
  // Shift every tag one stage and build the new EXE tag.
  always_comb begin
    valid_d      = {valid_q[FWD_DEPTH-1:0], 1'b0};
    wb_en_d      = {wb_en_q[FWD_DEPTH-1:0], 1'b0};
    is_load_d    = {is_load_q[FWD_DEPTH-1:0], 1'b0};
    valid_d[0]   = id_valid & ~stall_id & ~flush;
    wb_en_d[0]   = id_wb_en;
    is_load_d[0] = id_is_load;
    dest_d[0]    = id_dest;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      dest_d[k] = dest_q[k-1];
    end
  end

  // Tag registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q   <= '0;
      wb_en_q   <= '0;
      is_load_q <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      is_load_q <= is_load_d;
      dest_q    <= dest_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Forward selects: one matcher per EXE source operand.
  // ---------------------------------------------------------------------------
  for (genvar gi = 1; gi <= FWD_DEPTH; gi++) begin : g_flat
    assign stg_dest[(gi-1)*REG_AW +: REG_AW] = dest_q[gi];
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    fwd_match #(
      .REG_AW      (REG_AW),
      .FWD_DEPTH   (FWD_DEPTH),
      .ZERO_REG_EN (ZERO_REG_EN),
      .SEL_W       (SEL_W)
    ) u_match (
      .src_i         (exe_src[gi*REG_AW +: REG_AW]),
      .stg_valid_i   (valid_q[FWD_DEPTH:1]),
      .stg_wb_en_i   (wb_en_q[FWD_DEPTH:1]),
      .stg_is_load_i (is_load_q[FWD_DEPTH:1]),
      .stg_dest_i    (stg_dest),
      .sel_o         (fwd_sel[gi*SEL_W +: SEL_W]),
      .load_hit_o    (load_hit[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Stall counter (saturating).
  // ---------------------------------------------------------------------------
  // Count stall cycles, holding once all ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_id && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

  // A load in MEM feeding an EXE consumer means the stall was bypassed upstream.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!(|load_hit))
        else $error("hazard_forward_ctrl: EXE operand matches a load still in MEM");
    end
  end

endmodule
